config_rw_register_file: RTL
============================

// Module: config_rw_register_file
// PURPOSE
//  Application-side register file behind one write_configs[i]/read_configs[i] pair of the global config block.
//  Stores NUM_REGS 64-bit registers written from the host and tracks a per-register "written" flag that the application consumes.
//  Returns host reads through the read_config_i response handshake.
//  Addresses on both interfaces are local register indices, 0..NUM_REGS-1; the upstream splitter has already removed the base offset.
// PARAMETERS
//  NUM_REGS       8            number of 64-bit registers (>=1)
//  RESET_VALUES   '{default:0} logic[AXIL_DATA_BITS-1:0] [NUM_REGS]; register contents after reset
//  CONSUME_CLEARS '1           [NUM_REGS] bit mask; bit i=1 -> consume[i] clears valid_o[i]
// PORTS
//  clk          in   1                     clock
//  rst_n        in   1                     async active-low reset
//  wr           write_config_i.s  -        data[AXIL_DATA_BITS], addr[CONFIG_ADDR_BITS], valid; no backpressure
//  rd           read_config_i.s   -        read_addr/read_valid/read_ready, resp_data/resp_error/resp_valid/resp_ready
//  values       out  NUM_REGS x 64         current register contents
//  valid_o      out  NUM_REGS              register written since last consume
//  write_pulse  out  NUM_REGS              1-cycle strobe, registered, on each accepted write
//  consume      in   NUM_REGS              application acknowledges register i
// BEHAVIOUR
//  Reset (async assert, sync release via clk):
//   values = RESET_VALUES; valid_o = 0; write_pulse = 0; rd.resp_valid = 0; rd.resp_error = 0; rd.resp_data = 0.
//  Write path:
//   - wr.valid && wr.addr < NUM_REGS: values[addr] <= data, valid_o[addr] <= 1, write_pulse[addr] <= 1, all next edge.
//   - wr.valid with an out-of-range addr: no effect. wr.valid = 0: write_pulse <= 0.
//   - Every wr.valid beat is taken; there is no ready signal.
//   - Back-to-back writes to the same addr: the last write wins; write_pulse stays high both cycles.
//  Consume:
//   - consume[i] && CONSUME_CLEARS[i]: valid_o[i] <= 0.
//   - Same-cycle write to i and consume[i]: the write wins, valid_o[i] = 1.
//   - consume on a mask-0 bit is ignored.
//  Read path: one-entry response slot.
//   - rd.read_ready = !rd.resp_valid || rd.resp_ready (combinational).
//   - Read accepted when read_valid && read_ready. On the next edge: resp_valid <= 1.
//     - In range: resp_data <= values[read_addr] (pre-write value if a write hits the same addr that cycle), resp_error <= 0.
//     - Out of range: resp_data <= 0, resp_error <= 1.
//   - resp_valid && resp_ready with no new accept: resp_valid <= 0.
//   - Accept and drain in the same cycle: resp_valid stays 1 and the slot is reloaded.
//     This gives full throughput, 1 response/cycle with resp_ready tied high.
//   - resp_data and resp_error hold stable while resp_valid && !resp_ready.
//   - Latency from read accept to resp_valid is 1 cycle.
//  Reads never modify valid_o (no clear-on-read). Writes never stall reads, and reads never stall writes.
//  rst_n asserted mid-transaction: a pending response is dropped and read_ready = 1 after release.
//   The host side is reset by the same rst_n and does not expect the dropped response.
//  Widths: addr compare is unsigned over the full CONFIG_ADDR_BITS. NUM_REGS need not be a power of 2.
// STRUCTURE
//  config_pkg: AXIL_DATA_BITS, CONFIG_ADDR_BITS, and the typedef config_word_t = logic[AXIL_DATA_BITS-1:0].
//   This block adds nothing new to the package.
//  Sub-module config_resp_slot: the single-entry response register with its ready/valid logic.
//   Reused by other config consumers.
//  Top level: generate-for over NUM_REGS for the storage, valid_o and write_pulse flops, plus the read mux.
// TESTING (NUM_REGS=4, RESET_VALUES={0,0,0,'hDEAD}, CONSUME_CLEARS=4'b1111 unless stated)
//  1 Reset, then read addr 3 -> 1 cycle later resp_valid=1, resp_data='hDEAD, resp_error=0; valid_o=0.
//  2 Write addr 1 data 'h1234 -> next cycle values[1]='h1234, valid_o[1]=1, write_pulse=4'b0010 for exactly 1 cycle.
//    Then consume[1] -> valid_o[1]=0 and values[1] unchanged.
//  3 Write addr 2 and consume[2] in the same cycle -> valid_o[2]=1.
//    With CONSUME_CLEARS=4'b1011, consume[2] alone -> valid_o[2] stays 1.
//  4 Write addr 7 (out of range) -> no values/valid_o change.
//    Read addr 7 -> resp_error=1, resp_data=0.
//  5 resp_ready=0, read addr 0 -> resp_valid=1, read_ready=0, data held 5 cycles.
//    Then raise resp_ready with a read of addr 1 pending -> the response changes to addr 1 with no bubble.
//  6 Streaming reads 0,1,2,3 with resp_ready=1 -> 4 responses on 4 consecutive cycles.
//    Assert rst_n low mid-stream -> resp_valid=0 immediately, all state back to reset values.

Source files
------------

// File: rtl/config_pkg.sv
// Shared configuration-bus types and widths.
// Used by every config consumer hanging off the global config block.
package config_pkg;

    localparam int AXIL_DATA_BITS   = 64;
    localparam int CONFIG_ADDR_BITS = 8;

    typedef logic [AXIL_DATA_BITS-1:0] config_word_t;

endpackage

// File: rtl/config_if.sv
// Write and read config interfaces between the splitter and a consumer.
// Writes have no backpressure; reads use a request/response handshake.
interface write_config_i;
    import config_pkg::*;

    config_word_t                  data;
    logic [CONFIG_ADDR_BITS-1:0]   addr;
    logic                          valid;

    modport m (output data, addr, valid);
    modport s (input  data, addr, valid);
endinterface

interface read_config_i;
    import config_pkg::*;

    logic [CONFIG_ADDR_BITS-1:0]   read_addr;
    logic                          read_valid;
    logic                          read_ready;
    config_word_t                  resp_data;
    logic                          resp_error;
    logic                          resp_valid;
    logic                          resp_ready;

    modport m (
        output read_addr, read_valid, resp_ready,
        input  read_ready, resp_data, resp_error, resp_valid
    );
    modport s (
        input  read_addr, read_valid, resp_ready,
        output read_ready, resp_data, resp_error, resp_valid
    );
endinterface

// File: rtl/config_resp_slot.sv
// Single-entry response register with ready/valid handshake.
// Accept and drain in one cycle reloads the slot for full throughput.
module config_resp_slot #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_error,
    output logic         resp_valid,
    output logic [W-1:0] resp_data,
    output logic         resp_error,
    input  logic         resp_ready
);

    logic accept;

    assign in_ready = !resp_valid || resp_ready;
    assign accept   = in_valid && in_ready;

    // Load on accept, empty on drain, otherwise hold the response stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_error <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_data  <= in_data;
            resp_error <= in_error;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/config_rw_register_file.sv
// Host-writable register file with per-register written flags.
// Host reads return through a one-entry response slot.
module config_rw_register_file
    import config_pkg::*;
#(
    parameter int           NUM_REGS                 = 8,
    parameter config_word_t RESET_VALUES [NUM_REGS]  = '{default: '0},
    parameter logic [NUM_REGS-1:0] CONSUME_CLEARS    = '1
) (
    input  logic                clk,
    input  logic                rst_n,
    write_config_i.s            wr,
    read_config_i.s             rd,
    output config_word_t        values [NUM_REGS],
    output logic [NUM_REGS-1:0] valid_o,
    output logic [NUM_REGS-1:0] write_pulse,
    input  logic [NUM_REGS-1:0] consume
);

    config_word_t rd_word;
    logic         rd_in_range;

    assign rd_in_range = int'(rd.read_addr) < NUM_REGS;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        config_word_t value_q;
        logic         valid_q;
        logic         pulse_q;
        logic         hit;

        assign hit            = wr.valid && (int'(wr.addr) == i);
        assign values[i]      = value_q;
        assign valid_o[i]     = valid_q;
        assign write_pulse[i] = pulse_q;

        // Store writes; a write beats a same-cycle consume on the flag.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                value_q <= RESET_VALUES[i];
                valid_q <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= hit;
                if (hit) begin
                    value_q <= wr.data;
                    valid_q <= 1'b1;
                end else if (consume[i] && CONSUME_CLEARS[i]) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    // Read mux; out-of-range addresses select zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(rd.read_addr) == i) rd_word = values[i];
        end
    end

    config_resp_slot #(
        .W (AXIL_DATA_BITS)
    ) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (rd.read_valid),
        .in_ready   (rd.read_ready),
        .in_data    (rd_word),
        .in_error   (!rd_in_range),
        .resp_valid (rd.resp_valid),
        .resp_data  (rd.resp_data),
        .resp_error (rd.resp_error),
        .resp_ready (rd.resp_ready)
    );

endmodule
